// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment definitions shared by the display encoders and the
// scan decoder. Patterns are active-high, bit6..bit0 = segments g..a.
package seg_pkg;

   localparam int unsigned DIGIT_W = 4;

   localparam logic [6:0] BLANK_PAT = 7'h00;

   localparam logic [6:0] SEG_0 = 7'h3f;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5b;
   localparam logic [6:0] SEG_3 = 7'h4f;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6d;
   localparam logic [6:0] SEG_6 = 7'h7d;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7f;
   localparam logic [6:0] SEG_9 = 7'h6f;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7c;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5e;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: active-high 7-segment pattern -> digit value.
// SEG_SCAN_HEX_EN: when defined, A..F patterns also decode (10..15);
// otherwise they are reported as neither digit nor blank.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0]         pattern,
   output logic [DIGIT_W-1:0] value,
   output logic               is_digit,
   output logic               is_blank
);

   // Pattern lookup; anything unrecognised leaves both flags low.
   always_comb begin
      value    = '0;
      is_digit = 1'b0;
      is_blank = 1'b0;
      case (pattern)
         BLANK_PAT: is_blank = 1'b1;
         SEG_0: begin value = DIGIT_W'(0); is_digit = 1'b1; end
         SEG_1: begin value = DIGIT_W'(1); is_digit = 1'b1; end
         SEG_2: begin value = DIGIT_W'(2); is_digit = 1'b1; end
         SEG_3: begin value = DIGIT_W'(3); is_digit = 1'b1; end
         SEG_4: begin value = DIGIT_W'(4); is_digit = 1'b1; end
         SEG_5: begin value = DIGIT_W'(5); is_digit = 1'b1; end
         SEG_6: begin value = DIGIT_W'(6); is_digit = 1'b1; end
         SEG_7: begin value = DIGIT_W'(7); is_digit = 1'b1; end
         SEG_8: begin value = DIGIT_W'(8); is_digit = 1'b1; end
         SEG_9: begin value = DIGIT_W'(9); is_digit = 1'b1; end
`ifdef SEG_SCAN_HEX_EN
         SEG_A: begin value = DIGIT_W'(10); is_digit = 1'b1; end
         SEG_B: begin value = DIGIT_W'(11); is_digit = 1'b1; end
         SEG_C: begin value = DIGIT_W'(12); is_digit = 1'b1; end
         SEG_D: begin value = DIGIT_W'(13); is_digit = 1'b1; end
         SEG_E: begin value = DIGIT_W'(14); is_digit = 1'b1; end
         SEG_F: begin value = DIGIT_W'(15); is_digit = 1'b1; end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: snoops the multiplexed active-low seven-segment bus and
// recovers per-position digit value, decimal point and blank status once the
// bus has dwelt unchanged for SETTLE_CYC cycles. Hex digit decoding is
// enabled by defining SEG_SCAN_HEX_EN.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS     = 6,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [7:0]                seg_led,
   input  logic [DIGITS-1:0]         seg_sel,
   output logic [DIGIT_W*DIGITS-1:0] digit_bcd,
   output logic [DIGITS-1:0]         digit_vld,
   output logic [DIGITS-1:0]         digit_dp,
   output logic                      frame_done,
   output logic                      code_err,
   output logic                      sel_err
);

   localparam int unsigned      CNT_W   = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE_CYC - 1);

   logic [7:0]         sl_q, sl_p;
   logic [DIGITS-1:0]  ss_q, ss_p;
   logic [CNT_W-1:0]   settle_cnt;
   logic               dwell_done;
   logic [DIGITS-1:0]  cap_mask;

   logic               bus_chg;
   logic               capture;
   logic [6:0]         seg_pat;
   logic [DIGIT_W-1:0] dec_value;
   logic               dec_is_digit;
   logic               dec_is_blank;
   logic               pat_ok;
   logic [DIGITS-1:0]  sel_act;
   logic               sel_any;
   logic               sel_one;
   logic               sel_multi;
   logic [DIGITS-1:0]  pos_upd;
   logic               mask_full;

   // Register the bus once, plus one more stage for change detection.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sl_q <= '1;
         ss_q <= '1;
         sl_p <= '1;
         ss_p <= '1;
      end else begin
         sl_q <= seg_led;
         ss_q <= seg_sel;
         sl_p <= sl_q;
         ss_p <= ss_q;
      end
   end

   assign bus_chg = (sl_q != sl_p) || (ss_q != ss_p);

   // Capture fires once per dwell, on the cycle the counter shows SETTLE_CYC-1
   // with no change in flight; dwell_done blocks any repeat until the bus moves.
   assign capture = !bus_chg && !dwell_done && (settle_cnt == CNT_CAP);

   // Stability counter (saturating) and one-shot dwell flag.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         settle_cnt <= '0;
         dwell_done <= 1'b0;
      end else if (bus_chg) begin
         settle_cnt <= '0;
         dwell_done <= 1'b0;
      end else begin
         if (settle_cnt != CNT_MAX) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
         end
         if (capture) begin
            dwell_done <= 1'b1;
         end
      end
   end

   assign seg_pat = ~sl_q[6:0];

   seg_pattern_decode u_decode (
      .pattern  (seg_pat),
      .value    (dec_value),
      .is_digit (dec_is_digit),
      .is_blank (dec_is_blank)
   );

   assign pat_ok    = dec_is_digit || dec_is_blank;
   assign sel_act   = ~ss_q;
   assign sel_any   = |sel_act;
   assign sel_one   = sel_any && ((sel_act & (sel_act - DIGITS'(1))) == '0);
   assign sel_multi = sel_any && !sel_one;
   assign pos_upd   = (capture && sel_one && pat_ok) ? sel_act : '0;
   assign mask_full = &cap_mask;

   // Per-position results, frame tracking and one-cycle event pulses.
   // The mask is cleared on the frame_done cycle but a capture landing on the
   // same cycle is still recorded into the fresh frame.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         digit_bcd  <= '0;
         digit_vld  <= '0;
         digit_dp   <= '0;
         cap_mask   <= '0;
         frame_done <= 1'b0;
         code_err   <= 1'b0;
         sel_err    <= 1'b0;
      end else begin
         frame_done <= mask_full;
         code_err   <= capture && sel_one && !pat_ok;
         sel_err    <= capture && sel_multi;
         cap_mask   <= (mask_full ? '0 : cap_mask) | pos_upd;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (pos_upd[i]) begin
               digit_bcd[DIGIT_W*i +: DIGIT_W] <= dec_value;
               digit_vld[i]                    <= dec_is_digit;
               digit_dp[i]                     <= ~sl_q[7];
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scenarios plus randomized bus traffic checked
// against a dwell-based behavioural model of the display-bus sink.
module tb_seg_scan_decoder;

   localparam int unsigned DIGITS     = 6;
   localparam int unsigned SETTLE_CYC = 4;
   localparam logic [7:0]  LED_IDLE   = 8'hFF;
   localparam logic [5:0]  SEL_IDLE   = 6'h3F;
`ifdef SEG_SCAN_HEX_EN
   localparam int N_VALID = 16;
`else
   localparam int N_VALID = 10;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [7:0]  seg_led = 8'hFF;
   logic [5:0]  seg_sel = 6'h3F;
   logic [23:0] digit_bcd;
   logic [5:0]  digit_vld;
   logic [5:0]  digit_dp;
   logic        frame_done;
   logic        code_err;
   logic        sel_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [6:0] seg_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

   seg_scan_decoder #(.DIGITS(DIGITS), .SETTLE_CYC(SETTLE_CYC)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .seg_led    (seg_led),
      .seg_sel    (seg_sel),
      .digit_bcd  (digit_bcd),
      .digit_vld  (digit_vld),
      .digit_dp   (digit_dp),
      .frame_done (frame_done),
      .code_err   (code_err),
      .sel_err    (sel_err)
   );

   always #5 sys_clk = ~sys_clk;

   // Behavioural model: count identical consecutive bus samples; the dwell
   // acts once when SETTLE_CYC+1 identical samples have been seen, and its
   // effect is visible one edge later.
   int          m_bcd [DIGITS];
   logic [5:0]  m_vld = '0, m_dp = '0, m_mask = '0;
   logic        m_frame = 1'b0, m_code = 1'b0, m_sel = 1'b0;
   int          m_run = 0;
   logic [13:0] m_last = '1;
   logic        m_pend = 1'b0;
   logic [7:0]  m_pled = '1;
   logic [5:0]  m_psel = '1;
   int          m_nlow, m_pos, m_val;
   logic [6:0]  m_pat;

   initial begin
      forever begin
         @(posedge sys_clk);
         m_frame = 1'b0;
         m_code  = 1'b0;
         m_sel   = 1'b0;
         if (sys_rst) begin
            for (int i = 0; i < DIGITS; i++) m_bcd[i] = 0;
            m_vld  = '0;
            m_dp   = '0;
            m_mask = '0;
            m_run  = 0;
            m_last = {LED_IDLE, SEL_IDLE};
            m_pend = 1'b0;
         end else begin
            if (m_mask == 6'h3F) begin
               m_frame = 1'b1;
               m_mask  = '0;
            end
            if (m_pend) begin
               m_nlow = 0;
               m_pos  = 0;
               for (int i = 0; i < DIGITS; i++) begin
                  if (!m_psel[i]) begin
                     m_nlow++;
                     m_pos = i;
                  end
               end
               m_pat = ~m_pled[6:0];
               if (m_nlow > 1) begin
                  m_sel = 1'b1;
               end else if (m_nlow == 1) begin
                  m_val = -1;
                  for (int k = 0; k < N_VALID; k++) if (seg_tab[k] == m_pat) m_val = k;
                  if (m_pat == 7'h00) begin
                     m_bcd[m_pos]  = 0;
                     m_vld[m_pos]  = 1'b0;
                     m_dp[m_pos]   = ~m_pled[7];
                     m_mask[m_pos] = 1'b1;
                  end else if (m_val >= 0) begin
                     m_bcd[m_pos]  = m_val;
                     m_vld[m_pos]  = 1'b1;
                     m_dp[m_pos]   = ~m_pled[7];
                     m_mask[m_pos] = 1'b1;
                  end else begin
                     m_code = 1'b1;
                  end
               end
            end
            if ({seg_led, seg_sel} == m_last) begin
               if (m_run < 1000) m_run++;
            end else begin
               m_run = 1;
            end
            m_last = {seg_led, seg_sel};
            m_pend = (m_run == SETTLE_CYC + 1);
            m_pled = seg_led;
            m_psel = seg_sel;
         end
      end
   end

   task automatic apply_reset();
      sys_rst = 1'b1;
      seg_led = LED_IDLE;
      seg_sel = SEL_IDLE;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         seg_led = 8'($urandom);
         seg_sel = 6'($urandom);
         @(negedge sys_clk);
         n_cmp++;
         if ({digit_bcd, digit_vld, digit_dp, frame_done, code_err, sel_err} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_hold cyc=%0d got=%h required=0", c,
                     {digit_bcd, digit_vld, digit_dp, frame_done, code_err, sel_err});
         end
      end
      sys_rst = 1'b0;
      seg_led = LED_IDLE;
      seg_sel = SEL_IDLE;
      for (int c = 0; c < 6; c++) begin
         @(negedge sys_clk);
         n_cmp++;
         if ({digit_bcd, digit_vld, digit_dp, frame_done, code_err, sel_err} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_idle cyc=%0d got=%h required=0", c,
                     {digit_bcd, digit_vld, digit_dp, frame_done, code_err, sel_err});
         end
      end
   endtask

   task automatic test_single_digit();
      logic [23:0] eb;
      logic [5:0]  ev;
      apply_reset();
      seg_sel = 6'b111110;
      seg_led = ~8'h5b;
      for (int c = 1; c <= 10; c++) begin
         @(negedge sys_clk);
         eb = (c >= 6) ? 24'h000002 : 24'h0;
         ev = (c >= 6) ? 6'b000001 : 6'b0;
         n_cmp++;
         if ({digit_bcd, digit_vld, digit_dp} !== {eb, ev, 6'b0}) begin
            n_err++;
            $display("FAIL single_digit cyc=%0d got=%h/%b/%b required=%h/%b/000000",
                     c, digit_bcd, digit_vld, digit_dp, eb, ev);
         end
         n_cmp++;
         if ({frame_done, code_err, sel_err} !== 3'b000) begin
            n_err++;
            $display("FAIL single_pulses cyc=%0d got=%b required=000", c,
                     {frame_done, code_err, sel_err});
         end
      end
   endtask

   task automatic test_glitch();
      logic [5:0] ev;
      apply_reset();
      seg_sel = 6'b111101;
      for (int c = 0; c < 12; c++) begin
         seg_led = ((c / 3) % 2 == 0) ? ~8'h4f : ~8'h06;
         @(negedge sys_clk);
         n_cmp++;
         if ({digit_vld, code_err, sel_err} !== 8'b0) begin
            n_err++;
            $display("FAIL glitch_quiet cyc=%0d got=%b required=0", c,
                     {digit_vld, code_err, sel_err});
         end
      end
      seg_led = ~8'h4f;
      for (int c = 1; c <= 8; c++) begin
         @(negedge sys_clk);
         ev = (c >= 6) ? 6'b000010 : 6'b0;
         n_cmp++;
         if ({digit_vld, digit_bcd[7:4], code_err, sel_err} !== {ev, (c >= 6) ? 4'd3 : 4'd0, 2'b00}) begin
            n_err++;
            $display("FAIL glitch_settle cyc=%0d got vld=%b d1=%0d err=%b%b required vld=%b",
                     c, digit_vld, digit_bcd[7:4], code_err, sel_err, ev);
         end
      end
   endtask

   task automatic test_full_scan();
      int         frames, frame_at, errs, cyc;
      logic [7:0] led;
      apply_reset();
      frames = 0; frame_at = -1; errs = 0; cyc = 0;
      for (int p = 0; p < 7; p++) begin
         if (p < 6) seg_sel = ~(6'd1 << p);
         else       seg_sel = SEL_IDLE;
         if (p < 4) led = {1'(p == 1), seg_tab[p+1]};
         else       led = 8'h00;
         seg_led = ~led;
         for (int c = 0; c < 6; c++) begin
            @(negedge sys_clk);
            if (frame_done) begin frames++; frame_at = cyc; end
            if (code_err || sel_err) errs++;
            cyc++;
         end
      end
      n_cmp++;
      if (frames != 1 || frame_at != 36) begin
         n_err++;
         $display("FAIL scan_frame got pulses=%0d at=%0d required pulses=1 at=36", frames, frame_at);
      end
      n_cmp++;
      if ({digit_bcd, digit_vld, digit_dp} !== {24'h004321, 6'b001111, 6'b000010}) begin
         n_err++;
         $display("FAIL scan_digits got=%h/%b/%b required=004321/001111/000010",
                  digit_bcd, digit_vld, digit_dp);
      end
      n_cmp++;
      if (errs != 0) begin
         n_err++;
         $display("FAIL scan_errors got=%0d required=0", errs);
      end
   endtask

   task automatic test_errors();
      int serr, cerr;
      apply_reset();
      serr = 0; cerr = 0;
      seg_sel = 6'b111100;
      seg_led = ~8'h5b;
      for (int c = 0; c < 8; c++) begin
         @(negedge sys_clk);
         serr += int'(sel_err);
         cerr += int'(code_err);
      end
      n_cmp++;
      if (serr != 1 || cerr != 0 || digit_vld !== 6'b0) begin
         n_err++;
         $display("FAIL sel_err got sel=%0d code=%0d vld=%b required sel=1 code=0 vld=000000",
                  serr, cerr, digit_vld);
      end
      serr = 0; cerr = 0;
      seg_sel = 6'b111110;
      seg_led = ~8'h77;
      for (int c = 0; c < 8; c++) begin
         @(negedge sys_clk);
         serr += int'(sel_err);
         cerr += int'(code_err);
      end
`ifdef SEG_SCAN_HEX_EN
      n_cmp++;
      if (cerr != 0 || serr != 0 || digit_vld !== 6'b000001 || digit_bcd[3:0] !== 4'hA) begin
         n_err++;
         $display("FAIL hex_a got code=%0d vld=%b d0=%h required code=0 vld=000001 d0=a",
                  cerr, digit_vld, digit_bcd[3:0]);
      end
`else
      n_cmp++;
      if (cerr != 1 || serr != 0 || digit_vld !== 6'b0 || digit_bcd !== 24'h0) begin
         n_err++;
         $display("FAIL code_err got code=%0d vld=%b bcd=%h required code=1 vld=000000 bcd=0",
                  cerr, digit_vld, digit_bcd);
      end
`endif
   endtask

   task automatic test_reset_mid_dwell();
      logic [5:0] ev;
      apply_reset();
      seg_sel = 6'b111110;
      seg_led = ~8'h06;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge sys_clk);
         ev = (c >= 5) ? 6'b000001 : 6'b0;
         n_cmp++;
         if ({digit_vld, digit_bcd[3:0]} !== {ev, (c >= 5) ? 4'd1 : 4'd0}) begin
            n_err++;
            $display("FAIL mid_dwell_reset cyc=%0d got vld=%b d0=%0d required vld=%b",
                     c, digit_vld, digit_bcd[3:0], ev);
         end
      end
   endtask

   task automatic test_random();
      int          hold, r, cyc;
      logic [23:0] eb;
      logic [7:0]  led;
      logic [5:0]  sel;
      apply_reset();
      cyc = 0;
      for (int s = 0; s < 150; s++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       sel = ~(6'd1 << $urandom_range(0, 5));
         else if (r == 7) sel = SEL_IDLE;
         else             sel = 6'($urandom);
         r = $urandom_range(0, 7);
         if (r < 6)       led = ~{1'($urandom), seg_tab[$urandom_range(0, 15)]};
         else if (r == 6) led = ~{1'($urandom), 7'h00};
         else             led = 8'($urandom);
         hold = $urandom_range(2, 9);
         for (int h = 0; h < hold; h++) begin
            seg_sel = sel;
            seg_led = led;
            sys_rst = ($urandom_range(0, 79) == 0);
            @(negedge sys_clk);
            for (int i = 0; i < DIGITS; i++) eb[4*i +: 4] = 4'(m_bcd[i]);
            n_cmp++;
            if ({digit_bcd, digit_vld, digit_dp, frame_done, code_err, sel_err} !==
                {eb, m_vld, m_dp, m_frame, m_code, m_sel}) begin
               n_err++;
               $display("FAIL random cyc=%0d got=%h/%b/%b/%b%b%b required=%h/%b/%b/%b%b%b",
                        cyc, digit_bcd, digit_vld, digit_dp, frame_done, code_err, sel_err,
                        eb, m_vld, m_dp, m_frame, m_code, m_sel);
            end
            cyc++;
         end
      end
      sys_rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_glitch();
      test_full_scan();
      test_errors();
      test_reset_mid_dwell();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
